// File: rtl/bist_pkg.sv
// Shared definitions for the March C- BIST sequencer: FSM states,
// element indices and the per-element march table.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WR_ONLY,
    ST_RD,
    ST_CMP,
    ST_WR,
    ST_DONE
  } state_t;

  localparam logic [2:0] ELEM_M0   = 3'd0;
  localparam logic [2:0] ELEM_M1   = 3'd1;
  localparam logic [2:0] ELEM_M2   = 3'd2;
  localparam logic [2:0] ELEM_M3   = 3'd3;
  localparam logic [2:0] ELEM_M4   = 3'd4;
  localparam logic [2:0] ELEM_M5   = 3'd5;
  localparam logic [2:0] ELEM_LAST = ELEM_M5;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef struct packed {
    logic dir;
    logic exp_val;
    logic wr_val;
    logic has_read;
    logic has_write;
  } march_elem_t;

  // March C-: {w0} up, (r0,w1) up, (r1,w0) up, (r0,w1) down, (r1,w0) down, (r0) up
  function automatic march_elem_t march_entry(input logic [2:0] elem);
    march_elem_t e;
    e = '0;
    case (elem)
      ELEM_M0: e = '{dir: DIR_UP,   exp_val: 1'b0, wr_val: 1'b0, has_read: 1'b0, has_write: 1'b1};
      ELEM_M1: e = '{dir: DIR_UP,   exp_val: 1'b0, wr_val: 1'b1, has_read: 1'b1, has_write: 1'b1};
      ELEM_M2: e = '{dir: DIR_UP,   exp_val: 1'b1, wr_val: 1'b0, has_read: 1'b1, has_write: 1'b1};
      ELEM_M3: e = '{dir: DIR_DOWN, exp_val: 1'b0, wr_val: 1'b1, has_read: 1'b1, has_write: 1'b1};
      ELEM_M4: e = '{dir: DIR_DOWN, exp_val: 1'b1, wr_val: 1'b0, has_read: 1'b1, has_write: 1'b1};
      ELEM_M5: e = '{dir: DIR_UP,   exp_val: 1'b0, wr_val: 1'b0, has_read: 1'b1, has_write: 1'b0};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/bist_march_ctrl_if.sv
// Sequencer <-> datapath bundle: counter controls, memory strobes,
// and the counter/comparator status coming back.
interface bist_march_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              cnt_reset;
  logic              cnt_preset;
  logic              cnt_en;
  logic              up_down;
  logic              read;
  logic              write;
  logic              data;
  logic              carry;
  logic              is_equal;
  logic [ADDR_W-1:0] addr;

  modport master (
    output cnt_reset, cnt_preset, cnt_en, up_down, read, write, data,
    input  carry, is_equal, addr
  );

  modport slave (
    input  cnt_reset, cnt_preset, cnt_en, up_down, read, write, data,
    output carry, is_equal, addr
  );
endinterface

// File: rtl/bist_fail_log.sv
// Miscompare log: sticky fail flag, saturating counter and capture of
// the address/element of the first miscompare in a run.
module bist_fail_log #(
  parameter int ADDR_W     = 4,
  parameter int FAIL_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  cmp_valid,
  input  logic                  mismatch,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [2:0]            elem,
  output logic                  fail,
  output logic [FAIL_CNT_W-1:0] fail_count,
  output logic [ADDR_W-1:0]     fail_addr,
  output logic [2:0]            fail_elem
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      fail       <= 1'b0;
      fail_count <= '0;
      fail_addr  <= '0;
      fail_elem  <= '0;
    end else if (cmp_valid && mismatch) begin
      fail <= 1'b1;
      if (fail_count != '1)
        fail_count <= fail_count + FAIL_CNT_W'(1);
      // Capture only while the sticky flag is still clear, i.e. first miscompare.
      if (!fail) begin
        fail_addr <= addr;
        fail_elem <= elem;
      end
    end
  end

endmodule

// File: rtl/bist_march_ctrl.sv
// March C- sequencer driving the BIST counter/memory/comparator datapath.
// Optional: define BIST_STOP_ON_FAIL_EN to end the run at the first miscompare.
module bist_march_ctrl
  import bist_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int FAIL_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  bist_march_ctrl_if.master     dp,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [FAIL_CNT_W-1:0] fail_count,
  output logic [ADDR_W-1:0]     fail_addr,
  output logic [2:0]            fail_elem
);

  state_t      state, state_nx;
  logic [2:0]  elem, elem_nx;
  march_elem_t cur;
  logic        start_acc;
  logic        cmp_valid;
  logic        end_of_addr;

  assign cur = march_entry(elem);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      elem  <= '0;
    end else begin
      state <= state_nx;
      elem  <= elem_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx      = state;
    elem_nx       = elem;
    busy          = 1'b0;
    done          = 1'b0;
    start_acc     = 1'b0;
    cmp_valid     = 1'b0;
    end_of_addr   = 1'b0;
    dp.cnt_reset  = 1'b0;
    dp.cnt_preset = 1'b0;
    dp.cnt_en     = 1'b0;
    dp.up_down    = 1'b0;
    dp.read       = 1'b0;
    dp.write      = 1'b0;
    dp.data       = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        done = (state == ST_DONE);
        if (start) begin
          start_acc = 1'b1;
          elem_nx   = ELEM_M0;
          state_nx  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy          = 1'b1;
        dp.cnt_reset  = cur.dir;
        dp.cnt_preset = !cur.dir;
        state_nx      = cur.has_read ? ST_RD : ST_WR_ONLY;
      end
      ST_WR_ONLY: begin
        busy        = 1'b1;
        dp.write    = 1'b1;
        dp.data     = cur.wr_val;
        end_of_addr = 1'b1;
      end
      ST_RD: begin
        busy     = 1'b1;
        dp.read  = 1'b1;
        dp.data  = cur.exp_val;
        state_nx = ST_CMP;
      end
      ST_CMP: begin
        busy      = 1'b1;
        dp.data   = cur.exp_val;
        cmp_valid = 1'b1;
        if (cur.has_write) state_nx = ST_WR;
        else               end_of_addr = 1'b1;
      end
      ST_WR: begin
        busy        = 1'b1;
        dp.write    = 1'b1;
        dp.data     = cur.wr_val;
        end_of_addr = 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase

    // Direction is a property of the element, held through all its cycles.
    if (busy) dp.up_down = cur.dir;

    if (end_of_addr) begin
      if (!dp.carry) begin
        dp.cnt_en = 1'b1;
        state_nx  = cur.has_read ? ST_RD : ST_WR_ONLY;
      end else if (elem == ELEM_LAST) begin
        state_nx = ST_DONE;
      end else begin
        elem_nx  = elem + 3'd1;
        state_nx = ST_LOAD;
      end
    end

`ifdef BIST_STOP_ON_FAIL_EN
    if (cmp_valid && !dp.is_equal) begin
      dp.cnt_en = 1'b0;
      state_nx  = ST_DONE;
    end
`endif
  end

  bist_fail_log #(
    .ADDR_W     (ADDR_W),
    .FAIL_CNT_W (FAIL_CNT_W)
  ) u_fail_log (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_acc),
    .cmp_valid  (cmp_valid),
    .mismatch   (!dp.is_equal),
    .addr       (dp.addr),
    .elem       (elem),
    .fail       (fail),
    .fail_count (fail_count),
    .fail_addr  (fail_addr),
    .fail_elem  (fail_elem)
  );

endmodule

// File: doc/bist_march_ctrl.md
Name: bist_march_ctrl

Overview:
March C- sequencer for the memory BIST datapath.
- Drives the external up/down address counter (load-zero, load-max, step, direction) and the memory read/write/data strobes.
- Consumes the counter terminal flag (carry) and the read-data comparator result (is_equal).
- Logs failures: sticky flag, saturating count, first-fail address and element.
- Sits between the top-level BIST start/done interface and the counter/memory/comparator datapath.

Parameters:
ADDR_W, 4, address width; memory depth N = 2**ADDR_W
FAIL_CNT_W, 8, width of saturating miscompare counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin test; sampled only in IDLE or DONE
carry  in  1  counter at terminal address for current direction (N-1 when counting up, 0 when counting down)
is_equal  in  1  comparator: memory read data == mem_data; valid the cycle after mem_read
addr  in  ADDR_W  current counter value, used for fail capture
busy  out  1  test in progress
done  out  1  test complete; held until next accepted start or rst
fail  out  1  sticky: at least one miscompare in this run
fail_count  out  FAIL_CNT_W  miscompares this run, saturates at all-ones
fail_addr  out  ADDR_W  address of first miscompare
fail_elem  out  3  element index (0-5) of first miscompare
cnt_reset  out  1  counter load 0
cnt_preset  out  1  counter load N-1
cnt_en  out  1  counter step
up_down  out  1  1 = up, 0 = down
read  out  1  memory read strobe
write  out  1  memory write strobe
data  out  1  write data during write; expected data during read/compare

Behaviour:
- Reset: every output is 0; state IDLE; the fail log is cleared.
- rst mid-test aborts immediately with the same values; no partial done.
- States: IDLE, LOAD, WR_ONLY, RD, CMP, WR, DONE.
- Element encoding: ascending 1, descending 0.
  - M0 up (w0)
  - M1 up (r0, w1)
  - M2 up (r1, w0)
  - M3 down (r0, w1)
  - M4 down (r1, w0)
  - M5 up (r0)
- IDLE/DONE + start=1: clear the fail log, set elem=0, go to LOAD, busy=1, done=0.
- start while busy is ignored.
- LOAD (1 cycle): assert cnt_reset for up elements, cnt_preset for down elements; up_down = element direction. Next state: WR_ONLY for M0, else RD.
- WR_ONLY: write=1, data=0.
- RD: read=1, data=expected value.
- CMP: data held at expected value; is_equal sampled here. Next state: WR, or end-of-address for M5.
- WR: write=1, data=write value.
- End of address (last op of the element at the current address):
  - carry=0: cnt_en=1 in the same cycle (counter steps), and the next state is the element's first op.
  - carry=1: no step. Next state is LOAD of elem+1, or DONE after M5.
- up_down is held stable for the whole element.
- Latency: done rises on the clock edge 15N+6 cycles after the edge that sampled start (6 LOAD cycles + N + 4*3N + 2N op cycles). N=16 gives 246.
- Miscompare (CMP with is_equal=0):
  - fail <= 1.
  - fail_count increments unless at all-ones.
  - On the first miscompare only, capture addr into fail_addr and elem into fail_elem.
- DONE: busy=0, done=1. The fail log stays readable until the next start.

Optional Feature:
BIST_STOP_ON_FAIL_EN
- Defined: the first miscompare in CMP goes directly to DONE on the next edge. Log shows fail=1, fail_count=1, and the capture registers are valid.
- Undefined: the run always completes all six elements and counts every miscompare.

Decomposition:
- Shared package bist_pkg holds:
  - state encoding localparams
  - element index constants
  - the march table: per element direction, expected value, write value, has_read, has_write
- One sub-module, bist_fail_log: sticky fail, saturating counter, first-fail capture; controlled by clear and cmp_valid/mismatch strobes.

Test Plan:
- Bench setup: ADDR_W=2 (N=4) with a behavioural counter, 4x1 memory and comparator.
- Fault-free memory: start pulse -> busy next cycle; done=1 exactly 66 cycles after the start edge; fail=0, fail_count=0; total write strobes = 20, read strobes = 20.
- Direction/loads: check cnt_reset in LOAD of M0, M1, M2 and M5; check cnt_preset with up_down=0 in M3 and M4; cnt_en never asserted in a cycle where carry=1.
- Stuck-at-0 at address 2: fail=1, fail_addr=2, fail_elem=2 (first r1 in M2); fail_count=2 (M2 r1, M4 r1).
- Same fault with BIST_STOP_ON_FAIL_EN: done in the cycle after the first CMP miscompare, with fail_count=1 and fail_elem=2.
- Robustness: rst asserted mid-M3 -> all outputs 0 next cycle. start asserted during busy is ignored. A new start from DONE clears the fail log and reruns the full 66 cycles.
- Saturation: FAIL_CNT_W=2 with an all-bits-inverting memory -> fail_count sticks at 3.
